// File: rtl/commit_map_pkg.sv
// rtl/commit_map_pkg.sv - shared commit uop type, tag constants and commit-map state enum
package commit_map_pkg;

    localparam int TAG_W = 7;
    localparam int NM_W  = 5;
    localparam int SQN_W = 7;

    // Bit 6 set marks "no physical register"; such tags never go back to the free list.
    localparam logic [TAG_W-1:0] TAG_NONE = 7'h40;

    typedef struct packed {
        logic             valid;
        logic [NM_W-1:0]  nmDst;
        logic [TAG_W-1:0] tagDst;
        logic [SQN_W-1:0] sqN;
        logic             predicted;
    } CommitUOp;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REPLAY  = 2'd1,
        RESTORE = 2'd2
    } CMState;

endpackage

// File: rtl/commit_map_slotchain.sv
// rtl/commit_map_slotchain.sv - applies WIDTH in-order register writes to a map, returning per-slot previous tags
module commit_map_slotchain
    import commit_map_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int NUM_ARCH = 32
) (
    input  logic [TAG_W-1:0] map_in   [NUM_ARCH],
    input  CommitUOp         uops     [WIDTH],
    output logic [TAG_W-1:0] map_out  [NUM_ARCH],
    output logic [TAG_W-1:0] prev_tag [WIDTH],
    output logic [WIDTH-1:0] slot_wr
);

    logic unused_fields;

    // Later slots read the map as already modified by earlier slots of the same cycle.
    always_comb begin
        map_out       = map_in;
        unused_fields = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            unused_fields = unused_fields ^ (^uops[i].sqN) ^ uops[i].predicted;
            prev_tag[i]   = TAG_NONE;
            slot_wr[i]    = uops[i].valid && (uops[i].nmDst != '0);
            if (slot_wr[i]) begin
                prev_tag[i]              = map_out[uops[i].nmDst];
                map_out[uops[i].nmDst]   = uops[i].tagDst;
            end
        end
    end

endmodule

// File: rtl/commit_map.sv
// rtl/commit_map.sv - committed register map with tag freeing and mispredict replay/restore to rename
module commit_map
    import commit_map_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int NUM_ARCH  = 32,
    parameter int RESTORE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  CommitUOp         IN_comUOp        [WIDTH],
    input  logic             IN_mispredFlush,
    output logic [TAG_W-1:0] OUT_freeTag      [WIDTH],
    output logic [WIDTH-1:0] OUT_freeValid,
    output logic [NM_W-1:0]  OUT_restoreNm    [RESTORE_W],
    output logic [TAG_W-1:0] OUT_restoreTag   [RESTORE_W],
    output logic             OUT_restoreValid,
    output logic             OUT_restoreBusy,
    output logic [31:0]      OUT_commitCnt
);

    localparam int BEATS  = NUM_ARCH / RESTORE_W;
    localparam int RIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [RIDX_W-1:0] LAST_BEAT = RIDX_W'(BEATS - 1);

    CMState state_q, state_d;

    logic [TAG_W-1:0]  com_map_q  [NUM_ARCH];
    logic [TAG_W-1:0]  com_map_d  [NUM_ARCH];
    logic [TAG_W-1:0]  spec_map_q [NUM_ARCH];
    logic [TAG_W-1:0]  spec_map_d [NUM_ARCH];
    logic [RIDX_W-1:0] ridx_q, ridx_d;

    logic [TAG_W-1:0]  free_tag_q    [WIDTH];
    logic [TAG_W-1:0]  free_tag_d    [WIDTH];
    logic [WIDTH-1:0]  free_valid_q, free_valid_d;
    logic [NM_W-1:0]   restore_nm_q  [RESTORE_W];
    logic [NM_W-1:0]   restore_nm_d  [RESTORE_W];
    logic [TAG_W-1:0]  restore_tag_q [RESTORE_W];
    logic [TAG_W-1:0]  restore_tag_d [RESTORE_W];
    logic              restore_valid_q, restore_valid_d;
    logic              busy_q, busy_d;
    logic [31:0]       commit_cnt_q, commit_cnt_d;

    logic [TAG_W-1:0]  com_next   [NUM_ARCH];
    logic [TAG_W-1:0]  com_prev   [WIDTH];
    logic [WIDTH-1:0]  com_wr;
    logic [TAG_W-1:0]  spec_base  [NUM_ARCH];
    logic [TAG_W-1:0]  spec_next  [NUM_ARCH];
    logic [TAG_W-1:0]  spec_prev  [WIDTH];
    logic [WIDTH-1:0]  spec_wr;
    logic [31:0]       n_valid;
    logic [NM_W-1:0]   ridx_nm;
    logic              unused_spec;

    commit_map_slotchain #(.WIDTH(WIDTH), .NUM_ARCH(NUM_ARCH)) u_com_chain (
        .map_in   (com_map_q),
        .uops     (IN_comUOp),
        .map_out  (com_next),
        .prev_tag (com_prev),
        .slot_wr  (com_wr)
    );

    // Outside REPLAY the replay chain starts from the committed map, which is the snapshot on flush rise.
    assign spec_base = (state_q == REPLAY) ? spec_map_q : com_map_q;

    commit_map_slotchain #(.WIDTH(WIDTH), .NUM_ARCH(NUM_ARCH)) u_spec_chain (
        .map_in   (spec_base),
        .uops     (IN_comUOp),
        .map_out  (spec_next),
        .prev_tag (spec_prev),
        .slot_wr  (spec_wr)
    );

    always_comb begin
        unused_spec = ^spec_wr;
        for (int i = 0; i < WIDTH; i++) begin
            unused_spec = unused_spec ^ (^spec_prev[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (IN_mispredFlush) state_d = REPLAY;
            REPLAY:  if (!IN_mispredFlush) state_d = RESTORE;
            RESTORE: begin
                if (IN_mispredFlush) begin
                    state_d = REPLAY;
                end else if (ridx_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        com_map_d       = com_map_q;
        spec_map_d      = spec_map_q;
        ridx_d          = ridx_q;
        free_valid_d    = '0;
        restore_valid_d = 1'b0;
        commit_cnt_d    = commit_cnt_q;
        n_valid         = '0;
        ridx_nm         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            free_tag_d[i] = '0;
            n_valid       = n_valid + 32'(IN_comUOp[i].valid);
        end
        for (int k = 0; k < RESTORE_W; k++) begin
            restore_nm_d[k]  = '0;
            restore_tag_d[k] = '0;
        end

        if (!IN_mispredFlush) begin
            com_map_d    = com_next;
            commit_cnt_d = commit_cnt_q + n_valid;
            for (int i = 0; i < WIDTH; i++) begin
                if (com_wr[i]) begin
                    free_tag_d[i]   = com_prev[i];
                    free_valid_d[i] = !com_prev[i][TAG_W-1];
                end
            end
        end else begin
            spec_map_d = spec_next;
        end

        if (state_q == REPLAY && !IN_mispredFlush) begin
            ridx_d = '0;
        end

        if (state_q == RESTORE && !IN_mispredFlush) begin
            restore_valid_d = 1'b1;
            ridx_d          = ridx_q + 1'b1;
            for (int k = 0; k < RESTORE_W; k++) begin
                ridx_nm          = NM_W'(int'(ridx_q) * RESTORE_W + k);
                restore_nm_d[k]  = ridx_nm;
                restore_tag_d[k] = (ridx_nm == '0) ? TAG_NONE : spec_map_q[ridx_nm];
            end
        end

        // Busy covers the registered last beat, dropping one cycle after it.
        busy_d = (state_d != IDLE) || restore_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                com_map_q[r]  <= TAG_NONE;
                spec_map_q[r] <= TAG_NONE;
            end
            for (int i = 0; i < WIDTH; i++) begin
                free_tag_q[i] <= '0;
            end
            for (int k = 0; k < RESTORE_W; k++) begin
                restore_nm_q[k]  <= '0;
                restore_tag_q[k] <= '0;
            end
            ridx_q          <= '0;
            free_valid_q    <= '0;
            restore_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            commit_cnt_q    <= '0;
        end else begin
            com_map_q       <= com_map_d;
            spec_map_q      <= spec_map_d;
            ridx_q          <= ridx_d;
            free_tag_q      <= free_tag_d;
            free_valid_q    <= free_valid_d;
            restore_nm_q    <= restore_nm_d;
            restore_tag_q   <= restore_tag_d;
            restore_valid_q <= restore_valid_d;
            busy_q          <= busy_d;
            commit_cnt_q    <= commit_cnt_d;
        end
    end

    assign OUT_freeTag      = free_tag_q;
    assign OUT_freeValid    = free_valid_q;
    assign OUT_restoreNm    = restore_nm_q;
    assign OUT_restoreTag   = restore_tag_q;
    assign OUT_restoreValid = restore_valid_q;
    assign OUT_restoreBusy  = busy_q;
    assign OUT_commitCnt    = commit_cnt_q;

endmodule
